// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and right-shifting operand registers.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] diff_nxt;

   // Full-subtractor cell: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] fsub(input logic x, input logic y, input logic bi);
      logic d;
      logic bo;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
      return {bo, d};
   endfunction

   always_comb begin
      {br_nxt, d_bit} = fsub(sa[0], sb[0], br);
      diff_nxt        = {d_bit, sd[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         sd    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= bin;
                  cnt   <= '0;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= diff_nxt;
               br  <= br_nxt;
               cnt <= cnt + 1'b1;
               // The final bit is folded straight into the registered outputs.
               if (cnt == LAST) begin
                  diff  <= diff_nxt;
                  bout  <= br_nxt;
                  zero  <= (diff_nxt == '0);
                  ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
